// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM command port between two requesters and injects periodic refresh.
// Define SDRAM_ARB_RR_EN for round-robin P0/P1 arbitration; otherwise P0 has fixed priority.
module sdram_arbiter #(
  parameter int REFRESH_CYCLES = 374,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk_48mhz_i,
  input  logic        rst_n_i,
  input  logic        p0_req_i,
  input  logic        p0_wr_i,
  input  logic [1:0]  p0_bank_i,
  input  logic [12:0] p0_row_i,
  input  logic [8:0]  p0_col_i,
  input  logic [15:0] p0_wdata_i,
  input  logic        p1_req_i,
  input  logic        p1_wr_i,
  input  logic [1:0]  p1_bank_i,
  input  logic [12:0] p1_row_i,
  input  logic [8:0]  p1_col_i,
  input  logic [15:0] p1_wdata_i,
  output logic        p0_ack_o,
  output logic        p1_ack_o,
  output logic [15:0] rd_data_o,
  output logic [1:0]  grant_o,
  output logic [1:0]  sd_cmd_o,
  output logic [1:0]  sd_bank_o,
  output logic [12:0] sd_row_o,
  output logic [8:0]  sd_col_o,
  output logic [15:0] sd_din_o,
  input  logic        sd_status_i,
  input  logic [15:0] sd_data_read_i,
  output logic        err_timeout_o
);

  // IDLE pick winner | ISSUE drive cmd | WAIT_BUSY await busy | WAIT_DONE await ready | RESPOND ack
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESPOND
  } state_t;

  localparam logic [1:0] CMD_IDLE  = 2'd0;
  localparam logic [1:0] CMD_READ  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;
  localparam logic [1:0] CMD_REF   = 2'd3;
  localparam logic [8:0] REF_RELOAD = 9'(REFRESH_CYCLES - 1);
  localparam logic [6:0] TMO_LAST   = 7'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [1:0]  cmd_q;
  logic [1:0]  grant_q;
  logic [1:0]  sd_cmd_q;
  logic [1:0]  sd_bank_q;
  logic [12:0] sd_row_q;
  logic [8:0]  sd_col_q;
  logic [15:0] sd_din_q;
  logic [15:0] rd_data_q;
  logic        p0_ack_q;
  logic        p1_ack_q;
  logic        err_q;
  logic [6:0]  tmo_q;
  logic [8:0]  ref_cnt_q;
  logic [8:0]  ref_cnt_d;
  logic        ref_pend_q;
  logic        tmo_hit;

  logic        pick_p1;
  logic        sel_wr;
  logic [1:0]  sel_bank;
  logic [12:0] sel_row;
  logic [8:0]  sel_col;
  logic [15:0] sel_din;

`ifdef SDRAM_ARB_RR_EN
  logic        rr_last_p0_q;
`endif

  always_comb begin
`ifdef SDRAM_ARB_RR_EN
    // On a tie the port that was not served last wins.
    pick_p1 = p1_req_i && (!p0_req_i || rr_last_p0_q);
`else
    pick_p1 = p1_req_i && !p0_req_i;
`endif
    sel_wr    = pick_p1 ? p1_wr_i    : p0_wr_i;
    sel_bank  = pick_p1 ? p1_bank_i  : p0_bank_i;
    sel_row   = pick_p1 ? p1_row_i   : p0_row_i;
    sel_col   = pick_p1 ? p1_col_i   : p0_col_i;
    sel_din   = pick_p1 ? p1_wdata_i : p0_wdata_i;
    ref_cnt_d = (ref_cnt_q == '0) ? REF_RELOAD : ref_cnt_q - 9'd1;
    tmo_hit   = (tmo_q == TMO_LAST);
  end

  always_ff @(posedge clk_48mhz_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      cmd_q      <= CMD_IDLE;
      grant_q    <= '0;
      sd_cmd_q   <= CMD_IDLE;
      sd_bank_q  <= '0;
      sd_row_q   <= '0;
      sd_col_q   <= '0;
      sd_din_q   <= '0;
      rd_data_q  <= '0;
      p0_ack_q   <= 1'b0;
      p1_ack_q   <= 1'b0;
      err_q      <= 1'b0;
      tmo_q      <= '0;
      ref_cnt_q  <= REF_RELOAD;
      ref_pend_q <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
      rr_last_p0_q <= 1'b0;
`endif
    end else begin
      ref_cnt_q <= ref_cnt_d;
      // Expiry wins over the clear so a refresh is never lost; at most one is ever pending.
      if (ref_cnt_q == '0) begin
        ref_pend_q <= 1'b1;
      end else if (state_q == S_ISSUE && cmd_q == CMD_REF) begin
        ref_pend_q <= 1'b0;
      end
      p0_ack_q <= 1'b0;
      p1_ack_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (sd_status_i) begin
            if (ref_pend_q) begin
              cmd_q   <= CMD_REF;
              grant_q <= '0;
              state_q <= S_ISSUE;
            end else if (p0_req_i || p1_req_i) begin
              cmd_q     <= sel_wr ? CMD_WRITE : CMD_READ;
              grant_q   <= pick_p1 ? 2'b10 : 2'b01;
              sd_bank_q <= sel_bank;
              sd_row_q  <= sel_row;
              sd_col_q  <= sel_col;
              sd_din_q  <= sel_din;
`ifdef SDRAM_ARB_RR_EN
              rr_last_p0_q <= !pick_p1;
`endif
              state_q   <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          sd_cmd_q <= cmd_q;
          tmo_q    <= '0;
          state_q  <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          sd_cmd_q <= CMD_IDLE;
          tmo_q    <= tmo_q + 7'd1;
          if (!sd_status_i) begin
            state_q <= S_WAIT_DONE;
          end else if (tmo_hit) begin
            err_q     <= 1'b1;
            rd_data_q <= '0;
            state_q   <= S_RESPOND;
          end
        end
        S_WAIT_DONE: begin
          tmo_q <= tmo_q + 7'd1;
          if (sd_status_i) begin
            if (cmd_q == CMD_READ) begin
              rd_data_q <= sd_data_read_i;
            end
            state_q <= S_RESPOND;
          end else if (tmo_hit) begin
            err_q     <= 1'b1;
            rd_data_q <= '0;
            state_q   <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          p0_ack_q <= grant_q[0];
          p1_ack_q <= grant_q[1];
          grant_q  <= '0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign p0_ack_o      = p0_ack_q;
  assign p1_ack_o      = p1_ack_q;
  assign rd_data_o     = rd_data_q;
  assign grant_o       = grant_q;
  assign sd_cmd_o      = sd_cmd_q;
  assign sd_bank_o     = sd_bank_q;
  assign sd_row_o      = sd_row_q;
  assign sd_col_o      = sd_col_q;
  assign sd_din_o      = sd_din_q;
  assign err_timeout_o = err_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a behavioural SDRAM interface model.
// Expected grant order follows SDRAM_ARB_RR_EN when it is defined for the build.
module tb_sdram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_req = 1'b0, p0_wr = 1'b0;
  logic [1:0]  p0_bank = '0;
  logic [12:0] p0_row = '0;
  logic [8:0]  p0_col = '0;
  logic [15:0] p0_wdata = '0;
  logic        p1_req = 1'b0, p1_wr = 1'b0;
  logic [1:0]  p1_bank = '0;
  logic [12:0] p1_row = '0;
  logic [8:0]  p1_col = '0;
  logic [15:0] p1_wdata = '0;
  logic        p0_ack, p1_ack, err;
  logic [15:0] rd_data, sd_din;
  logic [1:0]  grant, sd_cmd, sd_bank;
  logic [12:0] sd_row;
  logic [8:0]  sd_col;
  logic        sd_status = 1'b0;
  logic [15:0] sd_data_read = '0;

  int n_checks = 0;
  int n_err = 0;

  bit          model_init = 1'b0;
  bit          model_stuck = 1'b0;
  int          busy_cycles = 3;
  int          busy_left = 0;
  logic [15:0] rd_val = '0;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [1:0]  grant;
    logic [1:0]  bank;
    logic [12:0] row;
    logic [8:0]  col;
    logic [15:0] din;
  } cmd_rec_t;

  cmd_rec_t cmd_log[$];
  int p0_acks = 0, p1_acks = 0;
  int cmd_run = 0, max_run = 0, ack_run = 0, max_ack_run = 0;

  sdram_arbiter dut (
    .clk_48mhz_i    (clk),
    .rst_n_i        (rst_n),
    .p0_req_i       (p0_req),
    .p0_wr_i        (p0_wr),
    .p0_bank_i      (p0_bank),
    .p0_row_i       (p0_row),
    .p0_col_i       (p0_col),
    .p0_wdata_i     (p0_wdata),
    .p1_req_i       (p1_req),
    .p1_wr_i        (p1_wr),
    .p1_bank_i      (p1_bank),
    .p1_row_i       (p1_row),
    .p1_col_i       (p1_col),
    .p1_wdata_i     (p1_wdata),
    .p0_ack_o       (p0_ack),
    .p1_ack_o       (p1_ack),
    .rd_data_o      (rd_data),
    .grant_o        (grant),
    .sd_cmd_o       (sd_cmd),
    .sd_bank_o      (sd_bank),
    .sd_row_o       (sd_row),
    .sd_col_o       (sd_col),
    .sd_din_o       (sd_din),
    .sd_status_i    (sd_status),
    .sd_data_read_i (sd_data_read),
    .err_timeout_o  (err)
  );

  always #5 clk = ~clk;

  // Interface model: samples commands on the falling edge, then stays busy for busy_cycles.
  always @(negedge clk) begin
    if (model_init) begin
      sd_status = 1'b0;
    end else if (busy_left > 0) begin
      busy_left = busy_left - 1;
      if (busy_left == 0) sd_status = 1'b1;
    end else if (sd_cmd != 2'd0 && !model_stuck) begin
      sd_status = 1'b0;
      busy_left = busy_cycles;
      if (sd_cmd == 2'd1) sd_data_read = rd_val;
    end else begin
      sd_status = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (sd_cmd != 2'd0) begin
      cmd_log.push_back({sd_cmd, grant, sd_bank, sd_row, sd_col, sd_din});
      cmd_run = cmd_run + 1;
      if (cmd_run > max_run) max_run = cmd_run;
    end else begin
      cmd_run = 0;
    end
    if (p0_ack) p0_acks = p0_acks + 1;
    if (p1_ack) p1_acks = p1_acks + 1;
    if (p0_ack || p1_ack) begin
      ack_run = ack_run + 1;
      if (ack_run > max_ack_run) max_ack_run = ack_run;
    end else begin
      ack_run = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_rec_t rec_at(input int i);
    cmd_rec_t r;
    r = '0;
    if (i < cmd_log.size()) r = cmd_log[i];
    return r;
  endfunction

  task automatic wait_ack(input int port, input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      tick(1);
      if ((port == 0) ? p0_ack : p1_ack) seen = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick(2);
    check("rst_sd_cmd", 32'(sd_cmd), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_acks", 32'({p0_ack, p1_ack}), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    bit       seen;
    int       b;
    int       a0;
    int       a1;
    cmd_rec_t r;
    logic [1:0] exp_g [4];

    // Interface initialising: nothing may be issued until status rises.
    model_init = 1'b1;
    do_reset();
    p0_wr = 1'b1; p0_bank = 2'd1; p0_row = 13'h0123; p0_col = 9'h045; p0_wdata = 16'hA5A5;
    p0_req = 1'b1;
    b = cmd_log.size();
    tick(100);
    check("init_no_cmd", 32'(cmd_log.size() - b), 32'd0);
    model_init = 1'b0;
    wait_ack(0, 40, seen);
    p0_req = 1'b0;
    check("init_p0_ack", 32'(seen), 32'd1);
    tick(1);
    check("init_p0_ack_one_cycle", 32'(p0_ack), 32'd0);
    check("init_cmd_count", 32'(cmd_log.size() - b), 32'd1);
    r = rec_at(b);
    check("init_cmd_write", 32'(r.cmd), 32'd2);
    check("init_grant", 32'(r.grant), 32'b01);
    check("init_bank", 32'(r.bank), 32'd1);
    check("init_row", 32'(r.row), 32'h0123);
    check("init_col", 32'(r.col), 32'h045);
    check("init_din", 32'(r.din), 32'hA5A5);

    // P1 read with 3 busy cycles.
    do_reset();
    busy_cycles = 3;
    rd_val = 16'hBEEF;
    p1_wr = 1'b0; p1_bank = 2'd2; p1_row = 13'h0ABC; p1_col = 9'h01F;
    p1_req = 1'b1;
    b = cmd_log.size();
    a0 = p0_acks;
    tick(1);
    check("p1rd_grant_idle_edge", 32'(grant), 32'b10);
    check("p1rd_cmd_not_yet", 32'(sd_cmd), 32'd0);
    tick(1);
    check("p1rd_cmd_read", 32'(sd_cmd), 32'd1);
    check("p1rd_grant_issue", 32'(grant), 32'b10);
    tick(1);
    check("p1rd_cmd_one_cycle", 32'(sd_cmd), 32'd0);
    check("p1rd_grant_busy", 32'(grant), 32'b10);
    wait_ack(1, 30, seen);
    check("p1rd_ack", 32'(seen), 32'd1);
    check("p1rd_rd_data", 32'(rd_data), 32'hBEEF);
    p1_req = 1'b0;
    tick(1);
    check("p1rd_ack_one_cycle", 32'(p1_ack), 32'd0);
    check("p1rd_grant_cleared", 32'(grant), 32'd0);
    tick(10);
    check("p1rd_cmd_count", 32'(cmd_log.size() - b), 32'd1);
    r = rec_at(b);
    check("p1rd_addr", 32'({r.bank, r.row, r.col}), 32'({2'd2, 13'h0ABC, 9'h01F}));
    check("p1rd_no_p0_ack", 32'(p0_acks - a0), 32'd0);

    // Both requesters continuously asserting.
    do_reset();
    busy_cycles = 2;
    p0_wr = 1'b0; p0_bank = 2'd0; p0_row = 13'h0005; p0_col = 9'h006;
    p1_wr = 1'b1; p1_bank = 2'd3; p1_row = 13'h0007; p1_col = 9'h008; p1_wdata = 16'h5A5A;
    p0_req = 1'b1;
    p1_req = 1'b1;
    b = cmd_log.size();
    for (int i = 0; i < 300 && (cmd_log.size() - b) < 4; i++) tick(1);
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick(20);
    check("both_cmd_count", 32'(cmd_log.size() - b), 32'd4);
`ifdef SDRAM_ARB_RR_EN
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    for (int i = 0; i < 4; i++) begin
      r = rec_at(b + i);
      check($sformatf("both_grant_%0d", i), 32'(r.grant), 32'(exp_g[i]));
      check($sformatf("both_cmd_%0d", i), 32'(r.cmd), (exp_g[i] == 2'b10) ? 32'd2 : 32'd1);
    end

    // Idle refresh cadence.
    do_reset();
    b = cmd_log.size();
    a0 = p0_acks;
    a1 = p1_acks;
    tick(380);
    check("ref1_count", 32'(cmd_log.size() - b), 32'd1);
    r = rec_at(b);
    check("ref1_cmd", 32'(r.cmd), 32'd3);
    check("ref1_grant", 32'(r.grant), 32'd0);
    check("ref1_no_ack", 32'((p0_acks - a0) + (p1_acks - a1)), 32'd0);
    tick(365);
    check("ref_before_748", 32'(cmd_log.size() - b), 32'd1);
    tick(15);
    check("ref2_count", 32'(cmd_log.size() - b), 32'd2);
    r = rec_at(b + 1);
    check("ref2_cmd", 32'(r.cmd), 32'd3);

    // Refresh pending while the interface is initialising beats a waiting P0.
    model_init = 1'b1;
    do_reset();
    p0_wr = 1'b1; p0_bank = 2'd1; p0_row = 13'h0042; p0_col = 9'h011; p0_wdata = 16'h1357;
    p0_req = 1'b1;
    b = cmd_log.size();
    tick(400);
    check("refp0_stalled", 32'(cmd_log.size() - b), 32'd0);
    model_init = 1'b0;
    wait_ack(0, 60, seen);
    p0_req = 1'b0;
    check("refp0_ack", 32'(seen), 32'd1);
    check("refp0_count", 32'(cmd_log.size() - b), 32'd2);
    r = rec_at(b);
    check("refp0_first_ref", 32'(r.cmd), 32'd3);
    r = rec_at(b + 1);
    check("refp0_then_write", 32'(r.cmd), 32'd2);
    check("refp0_then_grant", 32'(r.grant), 32'b01);

    // Good read, then a read the interface never answers.
    do_reset();
    busy_cycles = 2;
    rd_val = 16'h1234;
    p0_wr = 1'b0; p0_bank = 2'd1; p0_row = 13'h1FFF; p0_col = 9'h1FF;
    p0_req = 1'b1;
    wait_ack(0, 30, seen);
    p0_req = 1'b0;
    check("tmo_pre_ack", 32'(seen), 32'd1);
    check("tmo_pre_rd_data", 32'(rd_data), 32'h1234);
    check("tmo_pre_err", 32'(err), 32'd0);
    tick(2);
    model_stuck = 1'b1;
    b = cmd_log.size();
    p0_req = 1'b1;
    tick(30);
    check("tmo_not_yet", 32'(err), 32'd0);
    wait_ack(0, 80, seen);
    p0_req = 1'b0;
    check("tmo_ack", 32'(seen), 32'd1);
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_rd_data_zero", 32'(rd_data), 32'd0);
    check("tmo_cmd_count", 32'(cmd_log.size() - b), 32'd1);
    tick(5);
    check("tmo_err_sticky", 32'(err), 32'd1);

    // Reset while waiting for a long busy period.
    model_stuck = 1'b0;
    busy_cycles = 20;
    p1_wr = 1'b1; p1_bank = 2'd3; p1_row = 13'h1555; p1_col = 9'h0AA; p1_wdata = 16'hC3C3;
    p1_req = 1'b1;
    b = cmd_log.size();
    for (int i = 0; i < 10 && cmd_log.size() == b; i++) tick(1);
    tick(4);
    check("mid_grant", 32'(grant), 32'b10);
    check("mid_sd_din", 32'(sd_din), 32'hC3C3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cmd", 32'(sd_cmd), 32'd0);
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_addr", 32'({sd_bank, sd_row, sd_col}), 32'd0);
    check("mid_rst_din", 32'(sd_din), 32'd0);
    check("mid_rst_acks", 32'({p0_ack, p1_ack}), 32'd0);
    p1_req = 1'b0;
    a1 = p1_acks;
    tick(2);
    rst_n = 1'b1;
    tick(40);
    check("mid_no_ack_after", 32'(p1_acks - a1), 32'd0);
    check("mid_no_new_cmd", 32'(cmd_log.size() - b), 32'd1);
    busy_cycles = 2;
    rd_val = 16'h0F0F;
    p0_wr = 1'b0;
    p0_req = 1'b1;
    wait_ack(0, 30, seen);
    p0_req = 1'b0;
    check("mid_recover_ack", 32'(seen), 32'd1);
    check("mid_recover_rd_data", 32'(rd_data), 32'h0F0F);
    tick(5);

    check("no_back_to_back_cmd", 32'(max_run), 32'd1);
    check("ack_single_cycle", 32'(max_ack_run), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
